// File: rtl/conv_filter_sequencer.sv
// conv_filter_sequencer: runs a conv layer filter by filter, loading weights then issuing output windows under credit control
module conv_filter_sequencer #(
  parameter int NUM_FILTERS        = 4,
  parameter int FSEL_W             = 2,
  parameter int addressWidthFilter = 4,
  parameter int FILTER_BASE        = 0,
  parameter int OUT_ROWS           = 26,
  parameter int OUT_COLS           = 26,
  parameter int ROW_W              = 5,
  parameter int COL_W              = 5,
  parameter int MAX_OUT            = 4,
  parameter int OUT_W              = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          mem_en_o,
  output logic [FSEL_W-1:0]             mem_sel_o,
  output logic [addressWidthFilter-1:0] mem_addr_o,
  output logic                          weights_load_o,
  output logic                          win_valid_o,
  input  logic                          win_ready_i,
  output logic [ROW_W-1:0]              win_row_o,
  output logic [COL_W-1:0]              win_col_o,
  input  logic                          res_valid_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [FSEL_W-1:0] sel_q, sel_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [OUT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              armed_q;
  logic              busy_q, done_q, en_q, load_q;
  logic              accept, xfer, last_row, last_col, last_sel;

  assign accept   = (state_q == S_IDLE) && start_i;
  assign xfer     = valid_q && win_ready_i;
  assign last_row = row_q == ROW_W'(OUT_ROWS - 1);
  assign last_col = col_q == COL_W'(OUT_COLS - 1);
  assign last_sel = sel_q == FSEL_W'(NUM_FILTERS - 1);

  // Next-state sequencing of the layer: fetch, load, issue windows, drain per filter
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_i ? S_FETCH : S_IDLE;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   state_d = (xfer && last_row && last_col) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = (cnt_d != '0) ? S_DRAIN : last_sel ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: credit count, raster position, filter index, sticky error
  always_comb begin
    cnt_d   = (xfer && !res_valid_i) ? cnt_q + OUT_W'(1) :
              (!xfer && res_valid_i && cnt_q != '0) ? cnt_q - OUT_W'(1) : cnt_q;
    sel_d   = accept ? '0 : (state_q == S_DRAIN && state_d == S_FETCH) ? sel_q + FSEL_W'(1) : sel_q;
    row_d   = (state_q == S_LOAD) ? '0 : !(xfer && last_col) ? row_q : last_row ? '0 : row_q + ROW_W'(1);
    col_d   = (state_q == S_LOAD) ? '0 : !xfer ? col_q : last_col ? '0 : col_q + COL_W'(1);
    valid_d = (state_d == S_RUN) && ((valid_q && !xfer) || cnt_d < OUT_W'(MAX_OUT));
    err_d   = accept ? 1'b0 : err_q | (res_valid_i && cnt_q == '0 && armed_q);
  end

  // State and registered outputs; armed keeps post-reset stray results from flagging errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      armed_q <= armed_q | accept;
      busy_q  <= state_d inside {S_FETCH, S_LOAD, S_RUN, S_DRAIN};
      done_q  <= state_d == S_DONE;
      en_q    <= state_d == S_FETCH;
      load_q  <= state_d == S_LOAD;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign mem_en_o       = en_q;
  assign mem_sel_o      = sel_q;
  assign mem_addr_o     = addressWidthFilter'(FILTER_BASE);
  assign weights_load_o = load_q;
  assign win_valid_o    = valid_q;
  assign win_row_o      = row_q;
  assign win_col_o      = col_q;
endmodule

// File: tb/tb_conv_filter_sequencer.sv
// tb_conv_filter_sequencer: scoreboard bench for the filter sequencer on a 2-filter 2x3 layer
module tb_conv_filter_sequencer;
  localparam int NF = 2, R = 2, C = 3, MO = 2, BASE = 5;

  logic clk = 0, rst = 1, start = 0, ready = 0, res = 0;
  logic busy, done, err, mem_en, wl, valid;
  logic [1:0] sel;
  logic [3:0] addr;
  logic [4:0] row, col;

  int errors = 0, checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] w, hold_w;
  bit auto_res = 0, man_res = 0, rnd_ready = 0, ready_fix = 0, hold = 0;
  int pending = 0, ndone = 0, nxfer = 0;

  always #5 clk = ~clk;

  conv_filter_sequencer #(
    .NUM_FILTERS(NF), .FSEL_W(2), .addressWidthFilter(4), .FILTER_BASE(BASE),
    .OUT_ROWS(R), .OUT_COLS(C), .ROW_W(5), .COL_W(5), .MAX_OUT(MO), .OUT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .mem_en_o(mem_en), .mem_sel_o(sel), .mem_addr_o(addr), .weights_load_o(wl),
    .win_valid_o(valid), .win_ready_i(ready), .win_row_o(row), .win_col_o(col),
    .res_valid_i(res)
  );

  // Engine model and scoreboard: results return one cycle after each transfer, windows popped as accepted
  initial forever begin
    @(negedge clk);
    #1;
    res = auto_res ? (pending > 0) : man_res;
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    #1;
    if (rst) begin
      hold = 0;
      pending = 0;
    end else begin
      if (res && pending > 0) pending--;
      if (hold) begin
        checks++;
        if (valid !== 1'b1 || {sel, row, col} !== hold_w) begin
          errors++;
          $display("FAIL hold_stable: got valid=%b win=%h, required valid=1 win=%h", valid, {sel, row, col}, hold_w);
        end
      end
      if (valid && ready) begin
        nxfer++;
        pending++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL window_extra: got sel=%0d row=%0d col=%0d, required none", sel, row, col);
        end else begin
          w = exp_q.pop_front();
          if ({sel, row, col} !== w) begin
            errors++;
            $display("FAIL window: got sel=%0d row=%0d col=%0d, required sel=%0d row=%0d col=%0d",
                     sel, row, col, w[11:10], w[9:5], w[4:0]);
          end
        end
      end
      hold = valid && !ready;
      hold_w = {sel, row, col};
      if (done) ndone++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_layer();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          exp_q.push_back({2'(f), 5'(r), 5'(c)});
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input int from, output int n);
    n = from;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({busy, done, err, mem_en, wl, valid, sel, row, col, addr} !== {6'b0, 2'd0, 5'd0, 5'd0, 4'(BASE)}) begin
        errors++;
        $display("FAIL reset_idle: got %b, required %b", {busy, done, err, mem_en, wl, valid, sel, row, col, addr},
                 {6'b0, 2'd0, 5'd0, 5'd0, 4'(BASE)});
      end
    end
  endtask

  task automatic test_basic();
    int n;
    push_layer();
    ready_fix = 1;
    auto_res = 1;
    ndone = 0;
    pulse_start();
    checks++;
    if ({mem_en, wl, valid, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL basic_fetch: got en/load/valid/busy=%b, required 1001", {mem_en, wl, valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({mem_en, wl, valid, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL basic_load: got en/load/valid/busy=%b, required 0101", {mem_en, wl, valid, busy});
    end
    @(negedge clk);
    checks++;
    if ({mem_en, wl, valid, busy} !== 4'b0011) begin
      errors++;
      $display("FAIL basic_first_valid: got en/load/valid/busy=%b, required 0011", {mem_en, wl, valid, busy});
    end
    wait_done(3, n);
    checks++;
    if (n != 19) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d, required 19", n);
    end
    checks++;
    if ({busy, err} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_flags: got busy/err=%b, required 00", {busy, err});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ndone != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_complete: got done_pulses=%0d left=%0d, required 1 and 0", ndone, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int n;
    push_layer();
    rnd_ready = 1;
    auto_res = 1;
    ndone = 0;
    pulse_start();
    wait_done(1, n);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL bp_timeout: got %0d cycles, required done before 400", n);
    end
    repeat (4) @(negedge clk);
    rnd_ready = 0;
    checks++;
    if (ndone != 1 || exp_q.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete: got done_pulses=%0d left=%0d err=%b, required 1 0 0", ndone, exp_q.size(), err);
    end
  endtask

  task automatic test_credit_stall();
    int n;
    logic res_s[14] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    logic v_s[14]   = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    push_layer();
    ready_fix = 1;
    auto_res = 0;
    man_res = 0;
    ndone = 0;
    pulse_start();
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      man_res = res_s[i];
      checks++;
      if (valid !== v_s[i]) begin
        errors++;
        $display("FAIL credit_valid: cycle %0d got %b, required %b", i + 3, valid, v_s[i]);
      end
    end
    man_res = 0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 12 - 5) begin
      errors++;
      $display("FAIL credit_count: got %0d windows left, required 7", exp_q.size());
    end
    auto_res = 1;
    wait_done(0, n);
    repeat (4) @(negedge clk);
    checks++;
    if (n >= 400 || ndone != 1 || exp_q.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL credit_complete: got n=%0d done_pulses=%0d left=%0d err=%b, required done 1 0 0",
               n, ndone, exp_q.size(), err);
    end
  endtask

  task automatic test_error_restart();
    int n;
    auto_res = 0;
    @(negedge clk) man_res = 1;
    @(negedge clk) man_res = 0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b, required 1", err);
    end
    push_layer();
    auto_res = 1;
    ready_fix = 1;
    ndone = 0;
    pulse_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b, required 0", err);
    end
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    wait_done(6, n);
    checks++;
    if (n != 19) begin
      errors++;
      $display("FAIL restart_ignored: got done at %0d, required 19", n);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ndone != 1 || exp_q.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_complete: got done_pulses=%0d left=%0d err=%b, required 1 0 0", ndone, exp_q.size(), err);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    push_layer();
    auto_res = 1;
    ready_fix = 1;
    ndone = 0;
    pulse_start();
    n = 0;
    while (!(sel === 2'd1 && valid === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #3;
    auto_res = 0;
    rst = 1;
    #1;
    checks++;
    if ({busy, done, err, mem_en, wl, valid, sel, row, col, addr} !== {6'b0, 2'd0, 5'd0, 5'd0, 4'(BASE)}) begin
      errors++;
      $display("FAIL mid_reset_async: got %b, required %b", {busy, done, err, mem_en, wl, valid, sel, row, col, addr},
               {6'b0, 2'd0, 5'd0, 5'd0, 4'(BASE)});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    man_res = 1;
    @(negedge clk) man_res = 0;
    @(negedge clk);
    checks++;
    if (ndone != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got done_pulses=%0d err=%b, required 0 0", ndone, err);
    end
    push_layer();
    auto_res = 1;
    pulse_start();
    wait_done(1, n);
    repeat (4) @(negedge clk);
    checks++;
    if (n != 19 || ndone != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_rerun: got done_at=%0d done_pulses=%0d left=%0d, required 19 1 0", n, ndone, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_credit_stall();
    test_error_restart();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
